// File: rtl/hazard_unit.sv
// Pipeline hazard unit: tracks the destinations of in-flight instructions in
// EX/MEM/WB/RET and drives the registered forwarding selects for operand A/B.
// It also drives the combinational stall, flush_id and bubble_ex controls.
// Optional feature: define HAZARD_UNIT_STATS_EN to add saturating stall/flush
// event counters (stall_count, flush_count).
module hazard_unit #(
    parameter int REG_ADDR_SIZE = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid,
    input  logic [REG_ADDR_SIZE-1:0] id_rs1,
    input  logic [REG_ADDR_SIZE-1:0] id_rs2,
    input  logic                     id_use_rs1,
    input  logic                     id_use_rs2,
    input  logic [REG_ADDR_SIZE-1:0] id_rd,
    input  logic                     id_reg_write,
    input  logic                     id_mem_read,
    input  logic                     branch_taken,
    input  logic                     mem_busy,
    output logic [1:0]               fwd_a_sel,
    output logic [1:0]               fwd_b_sel,
    output logic                     stall,
    output logic                     flush_id,
    output logic                     bubble_ex
`ifdef HAZARD_UNIT_STATS_EN
    ,
    output logic [31:0]              stall_count,
    output logic [31:0]              flush_count
`endif
);

    localparam int NUM_STAGES = 4;  // 0=EX, 1=MEM, 2=WB, 3=RET

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_RET = 2'b11;

    typedef struct packed {
        logic                     valid;
        logic [REG_ADDR_SIZE-1:0] rd;
        logic                     reg_write;
        logic                     mem_read;
    } trk_t;

    trk_t trk_q [NUM_STAGES];
    trk_t trk_d [NUM_STAGES];

    logic [1:0] fwd_a_sel_q, fwd_a_sel_d;
    logic [1:0] fwd_b_sel_q, fwd_b_sel_d;

    logic [NUM_STAGES-1:0] hit_a;
    logic [NUM_STAGES-1:0] hit_b;
    logic [1:0]            sel_a;
    logic [1:0]            sel_b;
    logic                  load_use;

    // A stage only produces a forwardable value for a real, non-x0 write.
    function automatic logic src_hit(input trk_t s, input logic use_src,
                                     input logic [REG_ADDR_SIZE-1:0] rs);
        return use_src && s.valid && s.reg_write &&
               (s.rd != '0) && (s.rd == rs);
    endfunction

    // Youngest producer wins. A producer already in RET has written the
    // register file by the time the consumer reads it, so it maps to 00.
    function automatic logic [1:0] pick_sel(input logic [NUM_STAGES-1:0] h);
        if (h[0])      return SEL_MEM;
        else if (h[1]) return SEL_WB;
        else if (h[2]) return SEL_RET;
        else           return SEL_RF;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_hit
            assign hit_a[gi] = src_hit(trk_q[gi], id_use_rs1, id_rs1);
            assign hit_b[gi] = src_hit(trk_q[gi], id_use_rs2, id_rs2);
        end
    endgenerate

    // Forwarding choice and load-use detection for the instruction in ID.
    always_comb begin
        sel_a    = id_valid ? pick_sel(hit_a) : SEL_RF;
        sel_b    = id_valid ? pick_sel(hit_b) : SEL_RF;
        load_use = id_valid && trk_q[0].mem_read && (hit_a[0] || hit_b[0]);
    end

    // Pipeline controls; freeze dominates redirect, redirect dominates load-use.
    always_comb begin
        stall     = rst_n && (mem_busy || (load_use && !branch_taken));
        flush_id  = rst_n && !mem_busy && branch_taken;
        bubble_ex = rst_n && !mem_busy && (branch_taken || load_use);
    end

    // Next tracker contents and next forwarding selects.
    always_comb begin
        for (int i = 0; i < NUM_STAGES; i++) begin
            trk_d[i] = trk_q[i];
        end
        fwd_a_sel_d = fwd_a_sel_q;
        fwd_b_sel_d = fwd_b_sel_q;
        if (!mem_busy) begin
            for (int i = 1; i < NUM_STAGES; i++) begin
                trk_d[i] = trk_q[i-1];
            end
            if (branch_taken || load_use) begin
                trk_d[0]    = '0;
                fwd_a_sel_d = SEL_RF;
                fwd_b_sel_d = SEL_RF;
            end else begin
                trk_d[0].valid     = id_valid;
                trk_d[0].rd        = id_rd;
                trk_d[0].reg_write = id_reg_write;
                trk_d[0].mem_read  = id_mem_read;
                fwd_a_sel_d        = sel_a;
                fwd_b_sel_d        = sel_b;
            end
        end
    end

    // Tracker and select registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                trk_q[i] <= '0;
            end
            fwd_a_sel_q <= SEL_RF;
            fwd_b_sel_q <= SEL_RF;
        end else begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                trk_q[i] <= trk_d[i];
            end
            fwd_a_sel_q <= fwd_a_sel_d;
            fwd_b_sel_q <= fwd_b_sel_d;
        end
    end

    assign fwd_a_sel = fwd_a_sel_q;
    assign fwd_b_sel = fwd_b_sel_q;

`ifdef HAZARD_UNIT_STATS_EN
    logic [31:0] stall_count_q, stall_count_d;
    logic [31:0] flush_count_q, flush_count_d;

    // Saturating event counters; frozen cycles are not counted.
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (!mem_busy && load_use && !branch_taken && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
        if (!mem_busy && branch_taken && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed testbench for hazard_unit: each task drives one scenario and checks
// its own expected values. Inputs change 1ns after the rising edge.
module tb_hazard_unit;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         id_valid;
    logic [W-1:0] id_rs1, id_rs2, id_rd;
    logic         id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
    logic         branch_taken, mem_busy;
    logic [1:0]   fwd_a_sel, fwd_b_sel;
    logic         stall, flush_id, bubble_ex;
`ifdef HAZARD_UNIT_STATS_EN
    logic [31:0]  stall_count, flush_count;
    logic [31:0]  sc0, fc0;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_unit #(.REG_ADDR_SIZE(W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall(stall), .flush_id(flush_id), .bubble_ex(bubble_ex)
`ifdef HAZARD_UNIT_STATS_EN
        , .stall_count(stall_count), .flush_count(flush_count)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [W-1:0] rs1, input logic [W-1:0] rs2,
                          input logic u1, input logic u2, input logic [W-1:0] rd,
                          input logic rw, input logic mr);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr;
    endtask

    task automatic idle(input int n);
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_busy = 1'b1; branch_taken = 1'b1;
        set_id(1, 3, 3, 1, 1, 3, 1, 1);
        #3;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
        checks++; if (flush_id !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b expected 0", flush_id); end
        checks++; if (bubble_ex !== 1'b0) begin errors++; $display("FAIL reset_bubble: got %b expected 0", bubble_ex); end
        checks++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin errors++; $display("FAIL reset_sel: got %b/%b expected 00/00", fwd_a_sel, fwd_b_sel); end
        repeat (2) step();
        checks++; if (fwd_a_sel !== 2'b00 || stall !== 1'b0) begin errors++; $display("FAIL reset_held: got sel=%b stall=%b expected 00/0", fwd_a_sel, stall); end
        mem_busy = 1'b0; branch_taken = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        $display("test_reset done");
    endtask

    task automatic test_ex_forward();
        idle(4);
        set_id(1, 1, 2, 1, 1, 5, 1, 0);          // add x5
        step();
        set_id(1, 5, 5, 1, 1, 6, 1, 0);          // add x6,x5,x5
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ex_fwd_stall: got %b expected 0", stall); end
        step();
        checks++; if (fwd_a_sel !== 2'b10) begin errors++; $display("FAIL ex_fwd_a: got %b expected 10", fwd_a_sel); end
        checks++; if (fwd_b_sel !== 2'b10) begin errors++; $display("FAIL ex_fwd_b: got %b expected 10", fwd_b_sel); end
        set_id(1, 5, 0, 1, 0, 9, 1, 0);          // x5 producer now in MEM
        step();
        checks++; if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b00) begin errors++; $display("FAIL mem_fwd: got %b/%b expected 01/00", fwd_a_sel, fwd_b_sel); end
        set_id(1, 9, 6, 1, 1, 10, 1, 0);         // x9 in EX, x6 in MEM
        step();
        checks++; if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b01) begin errors++; $display("FAIL mix_fwd: got %b/%b expected 10/01", fwd_a_sel, fwd_b_sel); end
        $display("test_ex_forward done");
    endtask

    task automatic test_load_use();
        idle(4);
`ifdef HAZARD_UNIT_STATS_EN
        sc0 = stall_count;
`endif
        set_id(1, 2, 0, 1, 0, 7, 1, 1);          // lw x7
        step();
        set_id(1, 7, 1, 1, 1, 8, 1, 0);          // sub x8,x7,x1
        #1;
        checks++; if (stall !== 1'b1 || bubble_ex !== 1'b1 || flush_id !== 1'b0) begin errors++; $display("FAIL lu_first: got stall=%b bubble=%b flush=%b expected 1/1/0", stall, bubble_ex, flush_id); end
        step();
        checks++; if (stall !== 1'b0 || bubble_ex !== 1'b0) begin errors++; $display("FAIL lu_one_cycle: got stall=%b bubble=%b expected 0/0", stall, bubble_ex); end
        checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL lu_bubble_sel: got %b expected 00", fwd_a_sel); end
        step();
        checks++; if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b00) begin errors++; $display("FAIL lu_retry_sel: got %b/%b expected 01/00", fwd_a_sel, fwd_b_sel); end
`ifdef HAZARD_UNIT_STATS_EN
        checks++; if (stall_count !== sc0 + 32'd1) begin errors++; $display("FAIL lu_count: got %0d expected %0d", stall_count, sc0 + 32'd1); end
`endif
        $display("test_load_use done");
    endtask

    task automatic test_x0_and_ret();
        idle(4);
        set_id(1, 1, 1, 0, 0, 0, 1, 0); step();
        set_id(1, 1, 1, 0, 0, 0, 1, 0); step();
        set_id(1, 1, 1, 0, 0, 0, 1, 1); step(); // load into x0
        set_id(1, 0, 0, 1, 1, 4, 1, 0);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL x0_stall: got %b expected 0", stall); end
        step();
        checks++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin errors++; $display("FAIL x0_sel: got %b/%b expected 00/00", fwd_a_sel, fwd_b_sel); end
        idle(4);
        set_id(1, 1, 2, 1, 1, 3, 1, 0);          // add x3
        step();
        idle(2);
        set_id(1, 3, 0, 1, 0, 11, 1, 0);
        step();
        checks++; if (fwd_a_sel !== 2'b11) begin errors++; $display("FAIL ret_sel: got %b expected 11", fwd_a_sel); end
        idle(1);
        checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL nop_sel: got %b expected 00", fwd_a_sel); end
        $display("test_x0_and_ret done");
    endtask

    task automatic test_branch_override();
        idle(4);
`ifdef HAZARD_UNIT_STATS_EN
        sc0 = stall_count; fc0 = flush_count;
`endif
        set_id(1, 2, 0, 1, 0, 7, 1, 1);          // lw x7
        step();
        set_id(1, 7, 7, 1, 1, 8, 1, 0);
        branch_taken = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL br_stall: got %b expected 0", stall); end
        checks++; if (flush_id !== 1'b1 || bubble_ex !== 1'b1) begin errors++; $display("FAIL br_flush: got flush=%b bubble=%b expected 1/1", flush_id, bubble_ex); end
        step();
        branch_taken = 1'b0;
        checks++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin errors++; $display("FAIL br_sel: got %b/%b expected 00/00", fwd_a_sel, fwd_b_sel); end
        set_id(1, 0, 7, 0, 1, 12, 1, 0);         // reader of x7, load now in MEM
        #1;
        checks++; if (stall !== 1'b0 || flush_id !== 1'b0) begin errors++; $display("FAIL br_after: got stall=%b flush=%b expected 0/0", stall, flush_id); end
        step();
        checks++; if (fwd_b_sel !== 2'b01) begin errors++; $display("FAIL br_after_sel: got %b expected 01", fwd_b_sel); end
`ifdef HAZARD_UNIT_STATS_EN
        checks++; if (flush_count !== fc0 + 32'd1 || stall_count !== sc0) begin errors++; $display("FAIL br_count: got f=%0d s=%0d expected %0d/%0d", flush_count, stall_count, fc0 + 32'd1, sc0); end
`endif
        $display("test_branch_override done");
    endtask

    task automatic test_mem_busy();
        idle(4);
`ifdef HAZARD_UNIT_STATS_EN
        sc0 = stall_count; fc0 = flush_count;
`endif
        set_id(1, 1, 1, 1, 0, 2, 1, 0);          // add x2
        step();
        set_id(1, 2, 0, 1, 0, 7, 1, 1);          // lw x7,(x2)
        step();
        checks++; if (fwd_a_sel !== 2'b10) begin errors++; $display("FAIL busy_pre_sel: got %b expected 10", fwd_a_sel); end
        set_id(1, 7, 1, 1, 1, 8, 1, 0);
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            branch_taken = (i == 1);
            #1;
            checks++; if (stall !== 1'b1 || bubble_ex !== 1'b0 || flush_id !== 1'b0) begin errors++; $display("FAIL busy_ctrl[%0d]: got stall=%b bubble=%b flush=%b expected 1/0/0", i, stall, bubble_ex, flush_id); end
            branch_taken = 1'b0;
            step();
            checks++; if (fwd_a_sel !== 2'b10) begin errors++; $display("FAIL busy_hold[%0d]: got %b expected 10", i, fwd_a_sel); end
        end
        mem_busy = 1'b0;
        #1;
        checks++; if (stall !== 1'b1 || bubble_ex !== 1'b1) begin errors++; $display("FAIL busy_release: got stall=%b bubble=%b expected 1/1", stall, bubble_ex); end
        step();
        checks++; if (stall !== 1'b0 || fwd_a_sel !== 2'b00) begin errors++; $display("FAIL busy_one_stall: got stall=%b sel=%b expected 0/00", stall, fwd_a_sel); end
        step();
        checks++; if (fwd_a_sel !== 2'b01) begin errors++; $display("FAIL busy_retry_sel: got %b expected 01", fwd_a_sel); end
`ifdef HAZARD_UNIT_STATS_EN
        checks++; if (stall_count !== sc0 + 32'd1 || flush_count !== fc0) begin errors++; $display("FAIL busy_count: got s=%0d f=%0d expected %0d/%0d", stall_count, flush_count, sc0 + 32'd1, fc0); end
`endif
        $display("test_mem_busy done");
    endtask

    task automatic test_async_reset();
        idle(4);
        set_id(1, 1, 1, 1, 0, 2, 1, 0); step();  // add x2
        set_id(1, 2, 0, 1, 0, 7, 1, 1); step();  // lw x7,(x2): sel 10
        set_id(1, 7, 0, 1, 0, 8, 1, 0);
        #1;
        checks++; if (stall !== 1'b1 || fwd_a_sel !== 2'b10) begin errors++; $display("FAIL ar_pre: got stall=%b sel=%b expected 1/10", stall, fwd_a_sel); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (stall !== 1'b0 || bubble_ex !== 1'b0) begin errors++; $display("FAIL ar_ctrl: got stall=%b bubble=%b expected 0/0", stall, bubble_ex); end
        checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL ar_sel: got %b expected 00", fwd_a_sel); end
`ifdef HAZARD_UNIT_STATS_EN
        checks++; if (stall_count !== 32'd0 || flush_count !== 32'd0) begin errors++; $display("FAIL ar_count: got %0d/%0d expected 0/0", stall_count, flush_count); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step();
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ar_post_stall: got %b expected 0", stall); end
        step();
        checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL ar_post_sel: got %b expected 00", fwd_a_sel); end
        $display("test_async_reset done");
    endtask

    initial begin
        rst_n = 1'b0; mem_busy = 1'b0; branch_taken = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_ex_forward();
        test_load_use();
        test_x0_and_ret();
        test_branch_override();
        test_mem_busy();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
